// File: rtl/uart_tx_fifo_engine.sv
// UART transmitter with an integrated character FIFO and per-frame format latching.
// The frame format (length, parity, stop bits, bit time) is captured each time a character is popped.
module uart_tx_fifo_engine #(
    parameter int DEPTH  = 16,
    parameter int BAUD_W = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [7:0]               out_port,
    input  logic [BAUD_W-1:0]        baud_div,
    input  logic [1:0]               len,
    input  logic                     pen,
    input  logic                     ohel,
    input  logic                     stop2,
    output logic                     Tx,
    output logic                     TxRdy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]     PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [BAUD_W-1:0] TMR_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
    localparam logic [BAUD_W-1:0] TMR_ZERO = {BAUD_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity over the low L data bits; odd sense inverts the XOR.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] l, input logic odd);
        logic [7:0] mask;
        case (l)
            2'd0:    mask = 8'h1F;
            2'd1:    mask = 8'h3F;
            2'd2:    mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(d & mask)) ^ odd;
    endfunction

    logic [7:0]        mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    state_t            state_r;
    state_t            state_s;
    logic [BAUD_W-1:0] timer_r;
    logic [BAUD_W-1:0] timer_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_s;
    logic              stop_idx_r;
    logic              stop_idx_s;
    logic              tx_r;
    logic              tx_s;
    logic              done_r;
    logic              ovf_r;

    logic [7:0]        data_r;
    logic [1:0]        len_r;
    logic              pen_r;
    logic              ohel_r;
    logic              stop2_r;
    logic [BAUD_W-1:0] div_r;

    logic              push_s;
    logic              pop_s;
    logic              done_s;
    logic              bit_end_s;
    logic [2:0]        last_idx_s;

    assign full     = (count_r == DEPTH_C);
    assign empty    = (count_r == {CW{1'b0}});
    assign TxRdy    = ~full;
    assign count    = count_r;
    assign busy     = (state_r != IDLE);
    assign Tx       = tx_r;
    assign tx_done  = done_r;
    assign overflow = ovf_r;
    assign push_s   = load & ~full;

    // Next-state, bit timer and pop decision for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        timer_s    = timer_r;
        bit_idx_s  = bit_idx_r;
        stop_idx_s = stop_idx_r;
        pop_s      = 1'b0;
        done_s     = 1'b0;
        bit_end_s  = (timer_r == div_r);
        last_idx_s = 3'd4 + {1'b0, len_r};

        if (state_r == IDLE || bit_end_s) begin
            timer_s = TMR_ZERO;
        end else begin
            timer_s = timer_r + TMR_ONE;
        end

        case (state_r)
            IDLE: begin
                if (!empty) begin
                    pop_s   = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s && bit_idx_r == last_idx_s) begin
                    state_s    = pen_r ? PARITY : STOP;
                    stop_idx_s = 1'b0;
                end else if (bit_end_s) begin
                    bit_idx_s = bit_idx_r + 3'd1;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_s    = STOP;
                    stop_idx_s = 1'b0;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s && stop2_r && !stop_idx_r) begin
                    stop_idx_s = 1'b1;
                end else if (bit_end_s) begin
                    done_s = 1'b1;
                    if (!empty) begin
                        pop_s   = 1'b1;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Line level for the coming cycle, derived from where the sequencer is heading.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = data_r[bit_idx_s];
            PARITY:  tx_s = parity_bit(data_r, len_r, ohel_r);
            default: tx_s = 1'b1;
        endcase
    end

    // Sequencer state, timer, line register and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            timer_r    <= TMR_ZERO;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            stop_idx_r <= stop_idx_s;
            tx_r       <= tx_s;
            done_r     <= done_s;
            ovf_r      <= load & full;
        end
    end

    // Character and format captured at the pop so mid-frame input changes wait for the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r  <= 8'h00;
            len_r   <= 2'd0;
            pen_r   <= 1'b0;
            ohel_r  <= 1'b0;
            stop2_r <= 1'b0;
            div_r   <= TMR_ZERO;
        end else if (pop_s) begin
            data_r  <= mem_r[rd_ptr_r];
            len_r   <= len;
            pen_r   <= pen;
            ohel_r  <= ohel;
            stop2_r <= stop2;
            div_r   <= baud_div;
        end
    end

    // FIFO pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= out_port;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Self-checking bench: every cycle is compared against a queue-based waveform model,
// plus table-driven frame vectors and hand-written FIFO, config-latch and reset sequences.
module tb_uart_tx_fifo_engine;

    localparam int DEPTH  = 16;
    localparam int BAUD_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [7:0]        out_port;
    logic [BAUD_W-1:0] baud_div;
    logic [1:0]        len;
    logic              pen;
    logic              ohel;
    logic              stop2;
    logic              Tx;
    logic              TxRdy;
    logic              full;
    logic              empty;
    logic [4:0]        count;
    logic              busy;
    logic              tx_done;
    logic              overflow;

    uart_tx_fifo_engine #(.DEPTH(DEPTH), .BAUD_W(BAUD_W)) dut (
        .clk(clk), .reset(reset), .load(load), .out_port(out_port), .baud_div(baud_div),
        .len(len), .pen(pen), .ohel(ohel), .stop2(stop2), .Tx(Tx), .TxRdy(TxRdy),
        .full(full), .empty(empty), .count(count), .busy(busy), .tx_done(tx_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: queued characters and the remaining per-cycle line levels of the frame in flight.
    int unsigned mq[$];
    bit          wave[$];
    bit          e_done = 1'b0;
    bit          e_ovf  = 1'b0;

    typedef struct {
        logic [1:0]  l;
        logic        p;
        logic        o;
        logic        s2;
        int unsigned dv;
        logic [7:0]  ch;
        logic [15:0] bits;
        int          clocks;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic build_frame(input int unsigned c, input int l, input bit p, input bit o,
                               input bit s2, input int unsigned dv);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < l + 5; i++) begin
            bits.push_back(((c >> i) & 1) == 1);
            ones += (c >> i) & 1;
        end
        if (p) bits.push_back(((ones % 2) == 1) ^ o);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r <= int'(dv); r++) wave.push_back(bits[k]);
        end
    endtask

    // One clock: advance model with the inputs present at the edge, then compare all outputs.
    task automatic step();
        logic        ld, rs, p, o, s2;
        logic [7:0]  d;
        logic [1:0]  l;
        int unsigned dv;
        bit          push_ok;
        logic [11:0] got, req;
        ld = load; rs = reset; d = out_port; l = len; p = pen; o = ohel; s2 = stop2;
        dv = int'(baud_div);
        @(posedge clk);
        cyc++;
        if (rs) begin
            mq.delete();
            wave.delete();
            e_done = 1'b0;
            e_ovf  = 1'b0;
        end else begin
            push_ok = ld && (mq.size() < DEPTH);
            e_ovf   = ld && (mq.size() == DEPTH);
            e_done  = 1'b0;
            if (wave.size() > 0) begin
                void'(wave.pop_front());
                if (wave.size() == 0) e_done = 1'b1;
            end
            if (wave.size() == 0 && mq.size() > 0) build_frame(mq.pop_front(), int'(l), p, o, s2, dv);
            if (push_ok) mq.push_back(int'(d));
        end
        #1;
        got = {Tx, busy, count, full, empty, TxRdy, tx_done, overflow};
        req = {(wave.size() > 0) ? wave[0] : 1'b1, wave.size() > 0, 5'(mq.size()),
               mq.size() == DEPTH, mq.size() == 0, mq.size() != DEPTH, e_done, e_ovf};
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL model cycle %0d: got Tx,busy,count,full,empty,TxRdy,tx_done,overflow=%b required %b",
                     cyc, got, req);
        end
    endtask

    task automatic set_cfg(input logic [1:0] l, input logic p, input logic o, input logic s2, input int unsigned dv);
        len = l; pen = p; ohel = o; stop2 = s2; baud_div = BAUD_W'(dv);
    endtask

    initial begin
        int          n, bad, done_cnt, ovf_cnt, gaps, s, t1, t2, bitpos;
        bit          seen, started;
        vt[0] = '{l: 2'd3, p: 1'b0, o: 1'b0, s2: 1'b0, dv: 3, ch: 8'h55, bits: 16'h02AA, clocks: 40};
        vt[1] = '{l: 2'd2, p: 1'b1, o: 1'b0, s2: 1'b1, dv: 0, ch: 8'h83, bits: 16'h0606, clocks: 11};
        vt[2] = '{l: 2'd2, p: 1'b1, o: 1'b1, s2: 1'b1, dv: 0, ch: 8'h83, bits: 16'h0706, clocks: 11};
        vt[3] = '{l: 2'd0, p: 1'b1, o: 1'b1, s2: 1'b0, dv: 1, ch: 8'hFF, bits: 16'h00BE, clocks: 16};
        vt[4] = '{l: 2'd1, p: 1'b1, o: 1'b0, s2: 1'b0, dv: 2, ch: 8'h2A, bits: 16'h01D4, clocks: 27};

        reset = 1'b1; load = 1'b0; out_port = 8'h00;
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 3);
        step(); step();
        reset = 1'b0;
        check("reset_outputs", int'({Tx, TxRdy, full, empty, count, busy, tx_done, overflow}),
              int'({1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}));
        step();

        // Table-driven single-frame vectors.
        for (int v = 0; v < 5; v++) begin
            set_cfg(vt[v].l, vt[v].p, vt[v].o, vt[v].s2, vt[v].dv);
            out_port = vt[v].ch; load = 1'b1;
            step();
            load = 1'b0;
            check("latency_count", int'(count), 1);
            n = 0; bad = 0; seen = 1'b0;
            for (int k = 0; k < 400 && !seen; k++) begin
                step();
                if (tx_done) begin
                    seen = 1'b1;
                end else if (busy) begin
                    bitpos = n / (int'(vt[v].dv) + 1);
                    if (bitpos > 15 || Tx !== vt[v].bits[bitpos]) bad++;
                    n++;
                end
            end
            check("frame_done_seen", int'(seen), 1);
            check("frame_clocks", n, vt[v].clocks);
            check("frame_bit_errors", bad, 0);
            check("idle_after_done", int'(busy), 0);
            step();
        end

        // FIFO fill: 17 accepted (one is popped early), the 18th overflows.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 9);
        ovf_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            out_port = 8'(8'h30 + i); load = 1'b1;
            step();
            if (overflow) ovf_cnt++;
            if (i == 16) check("fifo_full", int'({full, TxRdy, count}), int'({1'b1, 1'b0, 5'd16}));
            if (i == 17) check("overflow_pulse", int'(overflow), 1);
        end
        load = 1'b0;
        done_cnt = 0; gaps = 0;
        for (int k = 0; k < 3000 && done_cnt < 17; k++) begin
            step();
            if (overflow) ovf_cnt++;
            if (tx_done) done_cnt++;
            if (!busy && done_cnt < 17) gaps++;
        end
        check("fifo_frames", done_cnt, 17);
        check("fifo_gaps", gaps, 0);
        check("overflow_count", ovf_cnt, 1);
        check("empty_after_drain", int'(empty), 1);
        step();

        // Format change mid-frame takes effect on the next frame only.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 3);
        out_port = 8'hA5; load = 1'b1; step();
        out_port = 8'h3C; step();
        load = 1'b0;
        s = busy ? cyc : -1;
        for (int k = 0; k < 8; k++) step();
        len = 2'd0; baud_div = BAUD_W'(1);
        t1 = -1; t2 = -1;
        for (int k = 0; k < 200 && t2 < 0; k++) begin
            step();
            if (tx_done && t1 < 0) t1 = cyc;
            else if (tx_done) t2 = cyc;
        end
        check("cfg_frame1_clocks", t1 - s, 40);
        check("cfg_frame2_clocks", t2 - t1, 14);
        step();

        // Reset during DATA with characters queued aborts and flushes.
        set_cfg(2'd3, 1'b0, 1'b0, 1'b0, 3);
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_port = 8'(8'hC0 + i); step();
        end
        load = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("busy_before_reset", int'(busy), 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("reset_mid_frame", int'({Tx, count, busy}), int'({1'b1, 5'd0, 1'b0}));
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (tx_done || overflow || !Tx || busy) bad++;
        end
        check("quiet_after_reset", bad, 0);

        // Randomized traffic with random format changes and occasional resets.
        for (int k = 0; k < 4000; k++) begin
            int pct;
            pct = (k < 1000) ? 5 : ((k < 2500) ? 40 : 90);
            if ($urandom_range(0, 19) == 0)
                set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3));
            load = ($urandom_range(0, 99) < pct);
            out_port = 8'($urandom_range(0, 255));
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        load = 1'b0; reset = 1'b0;
        for (int k = 0; k < 3000 && (wave.size() > 0 || mq.size() > 0); k++) step();
        check("random_drained", int'(wave.size() + mq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
